// File: rtl/sdram_pkt_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkt_pkg
// Shared definitions for the SDRAM packet packer:
//   - wr_state_e        : one-hot write-side FSM states
//   - HDR_WIDTH         : width of the byte-length header field
//   - MAX_BYTES_DEFAULT : default largest accepted frame, in bytes
// -----------------------------------------------------------------------------
package sdram_pkt_pkg;

    typedef enum logic [3:0] {
        WR_IDLE   = 4'b0001,
        WR_RECV   = 4'b0010,
        WR_COMMIT = 4'b0100,
        WR_DROP   = 4'b1000
    } wr_state_e;

    localparam int HDR_WIDTH         = 16;
    localparam int MAX_BYTES_DEFAULT = 1518;

    // Saturating add of a small increment to a 16-bit event counter.
    function automatic logic [15:0] sat_add16(input logic [15:0] value,
                                              input logic [1:0]  inc);
        logic [16:0] sum;
        sum = {1'b0, value} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/pkt_buf_ram.sv
// -----------------------------------------------------------------------------
// pkt_buf_ram
// Simple dual-port frame buffer: one write port, one read port with a
// registered output (data appears the cycle after re_i).
// Ports:
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable
//   raddr_i  : read address
//   rdata_o  : registered read data
// -----------------------------------------------------------------------------
module pkt_buf_ram #(
    parameter int ASIZE = 10,
    parameter int DW    = 16
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic             re_i,
    input  logic [ASIZE-1:0] raddr_i,
    output logic [DW-1:0]    rdata_o
);

    logic [DW-1:0] mem [0:(1<<ASIZE)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_pkt_packer.sv
// -----------------------------------------------------------------------------
// sdram_pkt_packer
// Store-and-forward front end for sdramfifo. Byte frames are packed
// big-endian into 16-bit words and held locally until the whole frame has
// arrived; a good frame is then released as a byte-length header word
// followed by its payload. Errored, oversized or overflowing frames are
// rewound out of the buffer and counted.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_valid, i_data   : byte strobe and byte
//   i_sof, i_eof      : first / last byte markers (qualified by i_valid)
//   i_err             : frame error (qualified by i_valid && i_eof)
//   o_wr, o_data      : write strobe and word towards sdramfifo
//   i_full            : sdramfifo full flag
//   o_drop_cnt        : saturating count of dropped frames
//   o_busy            : committed words still waiting to be sent
// -----------------------------------------------------------------------------
module sdram_pkt_packer
    import sdram_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_ASIZE  = 10,
    parameter int MAX_BYTES  = MAX_BYTES_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [7:0]            i_data,
    input  logic                  i_sof,
    input  logic                  i_eof,
    input  logic                  i_err,
    output logic                  o_wr,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_full,
    output logic [15:0]           o_drop_cnt,
    output logic                  o_busy
);

    localparam int                   PW      = BUF_ASIZE + 1;
    localparam logic [PW-1:0]        CAP     = {1'b1, {BUF_ASIZE{1'b0}}};
    localparam logic [HDR_WIDTH-1:0] MAX_CNT = HDR_WIDTH'(MAX_BYTES);

    // ---------------------------------------------------------------- write side
    wr_state_e            state_q;
    logic [PW-1:0]        wptr_q;
    logic [PW-1:0]        fstart_q;
    logic [PW-1:0]        cptr_q;
    logic [HDR_WIDTH-1:0] cnt_q;
    logic [7:0]           hi_q;
    logic [15:0]          drop_cnt_q;

    // ---------------------------------------------------------------- read side
    logic [PW-1:0]         rptr_q;
    logic                  rd_pend_q;
    logic [1:0]            pf_cnt_q;
    logic [DATA_WIDTH-1:0] pf0_q;
    logic [DATA_WIDTH-1:0] pf1_q;

    // ---------------------------------------------------------------- decode
    logic [PW-1:0]         used_w;
    logic [PW-1:0]         base_ptr;
    logic [PW-1:0]         base_p1;
    logic [PW-1:0]         used_base;
    logic [HDR_WIDTH-1:0]  cnt_nx;
    logic                  start_req;
    logic                  start_drop;
    logic                  need_word;
    logic                  recv_drop;
    logic [1:0]            drop_inc;
    logic                  ram_we;
    logic [BUF_ASIZE-1:0]  ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  pop;
    logic                  rd_issue;
    logic [2:0]            occ;

    always_comb begin
        used_w    = wptr_q - rptr_q;
        // A start-of-frame inside RECV first rewinds the abandoned frame, so
        // the new frame begins where the old one did.
        base_ptr  = (state_q == WR_RECV) ? fstart_q : wptr_q;
        base_p1   = base_ptr + PW'(1);
        used_base = base_ptr - rptr_q;
        cnt_nx    = cnt_q + HDR_WIDTH'(1);

        start_req  = i_valid && i_sof && (state_q != WR_COMMIT);
        // The header slot must fit; a single-byte frame needs a payload slot too.
        start_drop = (used_base == CAP) ||
                     (i_eof && (i_err || ((used_base + PW'(1)) == CAP)));

        // cnt_q is the index of the incoming byte: odd index completes a word.
        need_word = i_eof || cnt_q[0];
        recv_drop = (i_eof && i_err) || (cnt_nx > MAX_CNT) ||
                    (need_word && (used_w == CAP));

        drop_inc = 2'd0;
        unique case (state_q)
            WR_RECV: begin
                if (i_valid && i_sof) begin
                    drop_inc = start_drop ? 2'd2 : 2'd1;
                end else if (i_valid && recv_drop) begin
                    drop_inc = 2'd1;
                end
            end
            WR_COMMIT: begin
                if (i_valid && i_sof) begin
                    drop_inc = 2'd1;
                end
            end
            default: begin
                if (start_req && start_drop) begin
                    drop_inc = 2'd1;
                end
            end
        endcase

        ram_we    = 1'b0;
        ram_waddr = wptr_q[BUF_ASIZE-1:0];
        ram_wdata = '0;
        if (state_q == WR_COMMIT) begin
            ram_we    = 1'b1;
            ram_waddr = fstart_q[BUF_ASIZE-1:0];
            ram_wdata = DATA_WIDTH'(cnt_q);
        end else if (start_req) begin
            if (!start_drop && i_eof) begin
                ram_we    = 1'b1;
                ram_waddr = base_p1[BUF_ASIZE-1:0];
                ram_wdata = DATA_WIDTH'({i_data, 8'h00});
            end
        end else if ((state_q == WR_RECV) && i_valid && !recv_drop && need_word) begin
            ram_we    = 1'b1;
            ram_waddr = wptr_q[BUF_ASIZE-1:0];
            ram_wdata = cnt_q[0] ? DATA_WIDTH'({hi_q, i_data})
                                 : DATA_WIDTH'({i_data, 8'h00});
        end
    end

    // ---------------------------------------------------------------- write FSM
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= WR_IDLE;
            wptr_q     <= '0;
            fstart_q   <= '0;
            cptr_q     <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= sat_add16(drop_cnt_q, drop_inc);
            if (start_req) begin
                if (start_drop) begin
                    wptr_q  <= base_ptr;
                    state_q <= i_eof ? WR_IDLE : WR_DROP;
                end else begin
                    fstart_q <= base_ptr;
                    hi_q     <= i_data;
                    cnt_q    <= HDR_WIDTH'(1);
                    if (i_eof) begin
                        wptr_q  <= base_ptr + PW'(2);
                        state_q <= WR_COMMIT;
                    end else begin
                        wptr_q  <= base_p1;
                        state_q <= WR_RECV;
                    end
                end
            end else begin
                unique case (state_q)
                    WR_IDLE: begin
                        state_q <= WR_IDLE;
                    end
                    WR_DROP: begin
                        if (i_valid && i_eof) begin
                            state_q <= WR_IDLE;
                        end
                    end
                    WR_RECV: begin
                        if (i_valid) begin
                            if (recv_drop) begin
                                wptr_q  <= fstart_q;
                                state_q <= i_eof ? WR_IDLE : WR_DROP;
                            end else begin
                                cnt_q <= cnt_nx;
                                if (!cnt_q[0]) begin
                                    hi_q <= i_data;
                                end
                                if (need_word) begin
                                    wptr_q <= wptr_q + PW'(1);
                                end
                                if (i_eof) begin
                                    state_q <= WR_COMMIT;
                                end
                            end
                        end
                    end
                    WR_COMMIT: begin
                        // Header is written this cycle, so the frame may be
                        // published to the reader from the next cycle on.
                        cptr_q  <= wptr_q;
                        state_q <= WR_IDLE;
                    end
                    default: begin
                        state_q <= WR_IDLE;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- RAM
    pkt_buf_ram #(
        .ASIZE (BUF_ASIZE),
        .DW    (DATA_WIDTH)
    ) u_ram (
        .clk_i   (i_clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (rd_issue),
        .raddr_i (rptr_q[BUF_ASIZE-1:0]),
        .rdata_o (ram_rdata)
    );

    // ---------------------------------------------------------------- read side
    // Prefetch holds up to two words; a read in flight counts against that
    // space so a steady stream of one word per cycle never overfills it.
    always_comb begin
        pop      = (pf_cnt_q != 2'd0) && !i_full;
        occ      = {1'b0, pf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
        rd_issue = (rptr_q != cptr_q) && (occ < 3'd2);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rptr_q    <= '0;
            rd_pend_q <= 1'b0;
            pf_cnt_q  <= 2'd0;
            pf0_q     <= '0;
            pf1_q     <= '0;
        end else begin
            rd_pend_q <= rd_issue;
            if (rd_issue) begin
                rptr_q <= rptr_q + PW'(1);
            end
            pf_cnt_q <= pf_cnt_q - {1'b0, pop} + {1'b0, rd_pend_q};
            unique case ({pop, rd_pend_q})
                2'b10: begin
                    // Keep the last word on o_data once the prefetch drains.
                    if (pf_cnt_q == 2'd2) begin
                        pf0_q <= pf1_q;
                    end
                end
                2'b01: begin
                    if (pf_cnt_q == 2'd0) begin
                        pf0_q <= ram_rdata;
                    end else begin
                        pf1_q <= ram_rdata;
                    end
                end
                2'b11: begin
                    if (pf_cnt_q == 2'd1) begin
                        pf0_q <= ram_rdata;
                    end else begin
                        pf0_q <= pf1_q;
                        pf1_q <= ram_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_wr       = pop;
    assign o_data     = pf0_q;
    assign o_drop_cnt = drop_cnt_q;
    assign o_busy     = (rptr_q != cptr_q) || (pf_cnt_q != 2'd0) || rd_pend_q;

endmodule
